// File: rtl/arbiter_rr_1hot_pkg.sv
// ---------------------------------------------------------------------------
// arbiter_rr_1hot_pkg
//   Shared types and sizing helpers for the round-robin one-hot arbiter.
//   - arb_state_t : two-state controller encoding (IDLE, GRANT)
//   - clog2_min1  : ceil(log2(n)), never less than 1, so that index, pointer
//                   and hold-counter vectors always have at least one bit
// ---------------------------------------------------------------------------
package arbiter_rr_1hot_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick_1hot.sv
// ---------------------------------------------------------------------------
// rr_pick_1hot
//   Combinational round-robin selector. Finds the first set bit of req when
//   scanning upward from position ptr, wrapping from INPUTS-1 back to 0.
//
//   Ports
//     req      in  [INPUTS-1:0]  request vector
//     ptr      in  [IW-1:0]      scan start position (must be < INPUTS)
//     pick     out [INPUTS-1:0]  one-hot winner, all-zero if req is zero
//     pick_idx out [IW-1:0]      binary index of the winner, 0 if none
// ---------------------------------------------------------------------------
module rr_pick_1hot
  import arbiter_rr_1hot_pkg::*;
#(
  parameter int INPUTS = 4,
  parameter int IW     = clog2_min1(INPUTS)
) (
  input  logic [INPUTS-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [INPUTS-1:0] pick,
  output logic [IW-1:0]     pick_idx
);

  localparam logic [INPUTS-1:0] ONE = INPUTS'(1);

  logic [2*INPUTS-1:0] req_dbl;
  logic [2*INPUTS-1:0] req_shr;
  logic [INPUTS-1:0]   req_rot;
  logic [INPUTS-1:0]   lsb_rot;
  logic [2*INPUTS-1:0] lsb_dbl;
  logic [2*INPUTS-1:0] lsb_shl;
  logic [IW-1:0]       idx_terms [INPUTS];

  // Rotating a doubled copy avoids a variable-width wrap term: the low half
  // of {x,x} >> p is x rotated right by p, the high half of {x,x} << p is x
  // rotated left by p.
  assign req_dbl = {req, req};
  assign req_shr = req_dbl >> ptr;
  assign req_rot = req_shr[INPUTS-1:0];

  // Two's-complement trick isolates the lowest set bit of the rotated vector.
  assign lsb_rot = req_rot & (~req_rot + ONE);

  assign lsb_dbl = {lsb_rot, lsb_rot};
  assign lsb_shl = lsb_dbl << ptr;
  assign pick    = lsb_shl[2*INPUTS-1:INPUTS];

  // One-hot to binary: each lane contributes its own index when selected.
  generate
    for (genvar gi = 0; gi < INPUTS; gi++) begin : g_idx
      assign idx_terms[gi] = pick[gi] ? IW'(gi) : '0;
    end
  endgenerate

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < INPUTS; i++) begin
      pick_idx = pick_idx | idx_terms[i];
    end
  end

endmodule

// File: rtl/arbiter_rr_1hot.sv
// ---------------------------------------------------------------------------
// arbiter_rr_1hot
//   Registered round-robin arbiter producing the one-hot select of a
//   one-hot mux with default output. A grant is held for a whole transfer
//   and released on the last accepted beat, on request withdrawal, or when
//   the optional hold limit expires. On release the arbiter re-arbitrates
//   in the same cycle, so back-to-back grants have no idle bubble.
//
//   Parameters
//     INPUTS    number of requesters (1..32)
//     MAX_HOLD  cycles a grant may be held before forced release; 0 = off
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset
//     req        in   [INPUTS-1:0] level-sensitive requests
//     ready      in   consumer accepts the current beat
//     last       in   current beat is final (qualified by ready)
//     gnt        out  [INPUTS-1:0] registered one-hot grant, zero when idle
//     gnt_valid  out  registered, OR of gnt
//     gnt_idx    out  binary index of the grant, 0 when idle
//     timeout    out  one-cycle pulse after a release forced by the limit
// ---------------------------------------------------------------------------
module arbiter_rr_1hot
  import arbiter_rr_1hot_pkg::*;
#(
  parameter int INPUTS   = 4,
  parameter int MAX_HOLD = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [INPUTS-1:0]              req,
  input  logic                           ready,
  input  logic                           last,
  output logic [INPUTS-1:0]              gnt,
  output logic                           gnt_valid,
  output logic [clog2_min1(INPUTS)-1:0]  gnt_idx,
  output logic                           timeout
);

  localparam int IW = clog2_min1(INPUTS);
  localparam int HW = clog2_min1(MAX_HOLD);

  localparam logic [IW-1:0] LAST_IDX  = IW'(INPUTS - 1);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  arb_state_t          state_reg;
  logic [INPUTS-1:0]   gnt_reg;
  logic                gnt_valid_reg;
  logic [IW-1:0]       gnt_idx_reg;
  logic [IW-1:0]       ptr_reg;
  logic [HW-1:0]       hold_reg;
  logic                timeout_reg;

  logic [IW-1:0]       ptr_after;
  logic [IW-1:0]       pick_ptr;
  logic [INPUTS-1:0]   pick;
  logic [IW-1:0]       pick_idx;
  logic                any_pick;
  logic                req_held;
  logic                done_beat;
  logic                hold_expired;
  logic                normal_release;
  logic                release_now;
  logic [HW-1:0]       hold_inc;

  // Pointer value that makes the current holder the lowest priority.
  assign ptr_after = (gnt_idx_reg == LAST_IDX) ? '0 : gnt_idx_reg + IW'(1);

  // While a grant is active the selector is only consulted on release, and
  // then it must already see the advanced pointer; in IDLE it uses ptr_reg.
  assign pick_ptr = (state_reg == GRANT) ? ptr_after : ptr_reg;

  rr_pick_1hot #(
    .INPUTS (INPUTS),
    .IW     (IW)
  ) u_pick (
    .req      (req),
    .ptr      (pick_ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  assign any_pick = |pick;

  // gnt_reg is one-hot on the holder, so masking avoids indexing req by a
  // binary index that may be wider than the request vector needs.
  assign req_held       = |(req & gnt_reg);
  assign done_beat      = ready & last;
  assign hold_expired   = (MAX_HOLD != 0) && (hold_reg == HOLD_LAST);
  assign normal_release = done_beat | ~req_held;
  assign release_now    = normal_release | hold_expired;

  assign hold_inc = ((MAX_HOLD == 0) || (hold_reg == HOLD_LAST)) ? hold_reg
                                                                   : hold_reg + HW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      gnt_reg       <= '0;
      gnt_valid_reg <= 1'b0;
      gnt_idx_reg   <= '0;
      ptr_reg       <= '0;
      hold_reg      <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          timeout_reg <= 1'b0;
          if (|req) begin
            gnt_reg       <= pick;
            gnt_idx_reg   <= pick_idx;
            gnt_valid_reg <= 1'b1;
            hold_reg      <= '0;
            state_reg     <= GRANT;
          end
        end

        GRANT: begin
          if (release_now) begin
            ptr_reg       <= ptr_after;
            gnt_reg       <= pick;
            gnt_idx_reg   <= pick_idx;
            gnt_valid_reg <= any_pick;
            hold_reg      <= '0;
            // A coincident normal release masks the forced one.
            timeout_reg   <= hold_expired & ~normal_release;
            state_reg     <= any_pick ? GRANT : IDLE;
          end else begin
            hold_reg    <= hold_inc;
            timeout_reg <= 1'b0;
          end
        end

        default: begin
          state_reg     <= IDLE;
          gnt_reg       <= '0;
          gnt_valid_reg <= 1'b0;
          gnt_idx_reg   <= '0;
          timeout_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_valid = gnt_valid_reg;
  assign gnt_idx   = gnt_idx_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_arbiter_rr_1hot.sv
// ---------------------------------------------------------------------------
// tb_arbiter_rr_1hot
//   Three arbiter instances share one stimulus stream:
//     a: INPUTS=4, MAX_HOLD=0   b: INPUTS=4, MAX_HOLD=3   c: INPUTS=3, MAX_HOLD=2
//   Each is compared every cycle against a behavioural round-robin model
//   (scan loop, cycle count of the current grant). Directed scenarios add
//   fixed expected values; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_arbiter_rr_1hot;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ready;
  logic       last;

  logic [3:0] gnt_a, gnt_b;
  logic [2:0] gnt_c;
  logic       gv_a, gv_b, gv_c;
  logic [1:0] idx_a, idx_b, idx_c;
  logic       to_a, to_b, to_c;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  arbiter_rr_1hot #(.INPUTS(4), .MAX_HOLD(0)) dut_a (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .last(last),
    .gnt(gnt_a), .gnt_valid(gv_a), .gnt_idx(idx_a), .timeout(to_a)
  );

  arbiter_rr_1hot #(.INPUTS(4), .MAX_HOLD(3)) dut_b (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .last(last),
    .gnt(gnt_b), .gnt_valid(gv_b), .gnt_idx(idx_b), .timeout(to_b)
  );

  arbiter_rr_1hot #(.INPUTS(3), .MAX_HOLD(2)) dut_c (
    .clk(clk), .rst(rst), .req(req[2:0]), .ready(ready), .last(last),
    .gnt(gnt_c), .gnt_valid(gv_c), .gnt_idx(idx_c), .timeout(to_c)
  );

  // ---------------- reference model ----------------
  int m_n   [3] = '{4, 4, 3};
  int m_max [3] = '{0, 3, 2};
  bit m_busy[3];
  int m_idx [3];
  int m_ptr [3];
  int m_held[3];
  bit m_to  [3];

  function automatic int rr_scan(input logic [3:0] r, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      if (r[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  task automatic model_step(input int u, input logic [3:0] r_in, input bit rs,
                            input bit rd, input bit ls);
    logic [3:0] r;
    int w;
    bit norm, tmo;
    r = r_in;
    for (int i = m_n[u]; i < 4; i++) r[i] = 1'b0;
    if (rs) begin
      m_busy[u] = 0; m_idx[u] = 0; m_ptr[u] = 0; m_held[u] = 0; m_to[u] = 0;
    end else if (!m_busy[u]) begin
      m_to[u] = 0;
      w = rr_scan(r, m_ptr[u], m_n[u]);
      if (w >= 0) begin
        m_busy[u] = 1; m_idx[u] = w; m_held[u] = 1;
      end
    end else begin
      norm = (rd && ls) || !r[m_idx[u]];
      tmo  = (m_max[u] != 0) && (m_held[u] == m_max[u]);
      if (norm || tmo) begin
        m_ptr[u] = (m_idx[u] + 1) % m_n[u];
        m_to[u]  = tmo && !norm;
        w = rr_scan(r, m_ptr[u], m_n[u]);
        if (w >= 0) begin
          m_idx[u] = w; m_held[u] = 1;
        end else begin
          m_busy[u] = 0; m_idx[u] = 0; m_held[u] = 0;
        end
      end else begin
        m_held[u] = m_held[u] + 1;
        m_to[u]   = 0;
      end
    end
  endtask

  function automatic logic [31:0] e_gnt(input int u);
    return m_busy[u] ? (32'd1 << m_idx[u]) : 32'd0;
  endfunction

  function automatic logic [31:0] e_idx(input int u);
    return m_busy[u] ? 32'(m_idx[u]) : 32'd0;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cyc=%0d %s: got=%0h expected=%0h", cyc, tag, got, exp);
    end
  endtask

  task automatic check_models();
    check("a.gnt", 32'(gnt_a), e_gnt(0));
    check("a.gv",  32'(gv_a),  32'(m_busy[0]));
    check("a.idx", 32'(idx_a), e_idx(0));
    check("a.to",  32'(to_a),  32'(m_to[0]));
    check("b.gnt", 32'(gnt_b), e_gnt(1));
    check("b.gv",  32'(gv_b),  32'(m_busy[1]));
    check("b.idx", 32'(idx_b), e_idx(1));
    check("b.to",  32'(to_b),  32'(m_to[1]));
    check("c.gnt", 32'(gnt_c), e_gnt(2));
    check("c.gv",  32'(gv_c),  32'(m_busy[2]));
    check("c.idx", 32'(idx_c), e_idx(2));
    check("c.to",  32'(to_c),  32'(m_to[2]));
  endtask

  task automatic drive(input bit rs, input logic [3:0] r, input bit rd, input bit ls);
    rst = rs; req = r; ready = rd; last = ls;
  endtask

  // One clock: the model consumes the inputs seen at the edge, outputs are
  // sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    for (int u = 0; u < 3; u++) model_step(u, req, rst, ready, last);
    #1;
    cyc++;
    $display("cyc %0d rst=%b req=%b rdy=%b last=%b | a=%b/%0d b=%b/%0d to_b=%b c=%b/%0d to_c=%b",
             cyc, rst, req, ready, last, gnt_a, idx_a, gnt_b, idx_b, to_b,
             gnt_c, idx_c, to_c);
    check_models();
  endtask

  // Watchdog: the run has no open-ended waits, so this only trips on a
  // simulator-level stall.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0] rot_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    for (int u = 0; u < 3; u++) begin
      m_busy[u] = 0; m_idx[u] = 0; m_ptr[u] = 0; m_held[u] = 0; m_to[u] = 0;
    end
    drive(1, 4'b0000, 0, 0);

    // Reset and idle
    tick(); tick();
    drive(0, 4'b0000, 0, 0);
    tick();
    check("rst.gnt", 32'(gnt_a), 32'h0);
    check("rst.gv",  32'(gv_a),  32'h0);
    check("rst.idx", 32'(idx_a), 32'h0);
    check("rst.to",  32'(to_b),  32'h0);

    // Single request and release
    drive(0, 4'b0100, 0, 0);
    tick();
    check("single.gnt", 32'(gnt_a), 32'h4);
    check("single.idx", 32'(idx_a), 32'h2);
    tick(); tick();
    check("single.hold", 32'(gnt_a), 32'h4);
    drive(0, 4'b0000, 1, 1);
    tick();
    check("single.rel", 32'(gnt_a), 32'h0);
    check("single.rel_b_to", 32'(to_b), 32'h0);

    // Rotation fairness and wrap, from a freshly reset pointer
    drive(1, 4'b0000, 0, 0);
    tick();
    drive(0, 4'b1111, 1, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rot%0d.gnt", i), 32'(gnt_a), 32'(rot_exp[i]));
      check($sformatf("rot%0d.gv", i),  32'(gv_a),  32'h1);
    end

    // Simultaneous release and request (gnt_a is 1000 here)
    drive(0, 4'b1001, 1, 1);
    tick();
    check("simul.wrap", 32'(gnt_a), 32'h1);
    drive(0, 4'b1000, 1, 1);
    tick();
    check("simul.next", 32'(gnt_a), 32'h8);
    tick();
    check("simul.regrant", 32'(gnt_a), 32'h8);

    // Timeout on instance b (MAX_HOLD=3)
    drive(1, 4'b0000, 0, 0);
    tick();
    drive(0, 4'b0011, 0, 0);
    tick();
    check("tmo.g1", 32'(gnt_b), 32'h1);
    tick(); tick();
    check("tmo.g3", 32'(gnt_b), 32'h1);
    check("tmo.to_pre", 32'(to_b), 32'h0);
    tick();
    check("tmo.gnt", 32'(gnt_b), 32'h2);
    check("tmo.pulse", 32'(to_b), 32'h1);
    check("tmo.nolimit", 32'(gnt_a), 32'h1);
    tick();
    check("tmo.pulse_end", 32'(to_b), 32'h0);
    check("tmo.hold", 32'(gnt_b), 32'h2);
    tick();
    drive(0, 4'b0011, 1, 1);
    tick();
    check("tmo_last.gnt", 32'(gnt_b), 32'h1);
    check("tmo_last.to", 32'(to_b), 32'h0);

    // Reset mid-grant
    drive(1, 4'b0000, 0, 0);
    tick();
    drive(0, 4'b0010, 0, 0);
    tick(); tick();
    check("midrst.pre", 32'(gnt_a), 32'h2);
    drive(1, 4'b0010, 0, 0);
    tick();
    check("midrst.gnt", 32'(gnt_a), 32'h0);
    check("midrst.gv",  32'(gv_a),  32'h0);
    drive(0, 4'b1111, 0, 0);
    tick();
    check("midrst.ptr0", 32'(gnt_a), 32'h1);

    // Randomized phase: requests persist for a few cycles so grants are held
    // long enough to exercise the hold limit.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      ready = $urandom_range(0, 1) == 1;
      last  = $urandom_range(0, 2) == 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
